reg_dump_reader: RTL

- Sequential reader for the processor register file. On a Start pulse it walks every register address through one register-file read port and streams each (address, data) pair out over a valid/ready handshake.
- Used by the test/debug path to dump architectural state at program end. It sits beside the register file and drives one read-address port.
- It never writes the register file.

---
 rtl/reg_dump_reader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// ----------------------------------------------------------------------------
// reg_dump_reader
//
// Walks every register-file address through one combinational read port and
// streams each (address, data) pair out over a valid/ready handshake.
// A dump takes one FETCH cycle plus at least one SEND cycle per register.
// The block never writes the register file.
//
// Ports:
//   Clk      in   1  system clock, posedge active
//   Reset    in   1  asynchronous, active-high reset (abandons a dump, no Done)
//   Start    in   1  request a full dump; sampled only while idle
//   Raddr    out  A  register-file read address (always the internal counter)
//   RegData  in   W  combinational read data for Raddr
//   Ready    in   1  consumer accepts the current beat
//   Valid    out  1  DataOut/AddrOut hold a beat
//   DataOut  out  W  register contents of the current beat
//   AddrOut  out  A  register address of the current beat
//   Busy     out  1  dump in progress
//   Done     out  1  one-cycle pulse after the final beat is accepted
// ----------------------------------------------------------------------------
module reg_dump_reader #(
    parameter int W = 8,
    parameter int A = 3
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    output logic [A-1:0] Raddr,
    input  logic [W-1:0] RegData,
    input  logic         Ready,
    output logic         Valid,
    output logic [W-1:0] DataOut,
    output logic [A-1:0] AddrOut,
    output logic         Busy,
    output logic         Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND
    } state_t;

    localparam logic [A-1:0] LAST_ADDR = '1;

    state_t         r_state;
    state_t         w_next_state;
    logic [A-1:0]   r_cnt;
    logic [W-1:0]   r_data;
    logic [A-1:0]   r_addr;
    logic           r_done;

    logic           w_handshake;
    logic           w_last;

    assign w_handshake = (r_state == S_SEND) && Ready;
    assign w_last      = (r_cnt == LAST_ADDR);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred for w_next_state.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (Start) w_next_state = S_FETCH;
            S_FETCH: w_next_state = S_SEND;
            S_SEND:  if (w_handshake) w_next_state = w_last ? S_IDLE : S_FETCH;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    // Valid is exactly "in SEND": it rises after the FETCH edge and drops on
    // the handshake edge, so decoding it from state is identical to a flop
    // and clears instantly on reset.
    always_comb begin
        Busy    = (r_state != S_IDLE);
        Valid   = (r_state == S_SEND);
        Raddr   = r_cnt;
        DataOut = r_data;
        AddrOut = r_addr;
        Done    = r_done;
    end

    // ------------------------------------------------------------------
    // Datapath: counter, beat capture, Done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_addr <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (Start) r_cnt <= '0;
                end
                S_FETCH: begin
                    // Snapshot the register now; later writes do not touch
                    // this beat.
                    r_data <= RegData;
                    r_addr <= r_cnt;
                end
                S_SEND: begin
                    if (w_handshake) begin
                        if (w_last) begin
                            r_cnt  <= '0;
                            r_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
